systolic_feeder: RTL and testbench

//   Tile-row buffer directly upstream of the systolic skew stage. Accepts PORTS-lane rows from the

---
 rtl/systolic_feeder_if.sv | 10 +
 rtl/systolic_feeder.sv | 105 ++++++++++
 tb/tb_systolic_feeder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: row load port plus stream control/status between the load path and systolic_feeder.
interface systolic_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PORTS = 8
);
    logic wr_valid, wr_ready, start, busy, done, out_valid;
    logic [PORTS-1:0][DATA_WIDTH-1:0] wr_data, out;
    modport master (output wr_valid, wr_data, start, input wr_ready, busy, done, out, out_valid);
    modport slave (input wr_valid, wr_data, start, output wr_ready, busy, done, out, out_valid);
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers tile rows, streams them one per cycle into the skew stage, then flushes PORTS-1 zero rows.
// Define SYSTOLIC_FEEDER_DOUBLE_BUF_EN for two ping-pong banks so the next tile loads while one streams.
module systolic_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int PORTS = 8,
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic rst_n,
    systolic_feeder_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int FW = PORTS > 2 ? $clog2(PORTS) : 1;
    localparam logic [FW-1:0] FLAST = FW'(PORTS > 1 ? PORTS - 2 : 0);
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
    typedef logic [PORTS-1:0][DATA_WIDTH-1:0] row_t;
    state_t state;
    logic [CW-1:0] len, rd_ptr, wfill;
    logic [FW-1:0] fcnt;
    logic beat, go, fin;
    row_t rd_row, head;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
    logic wsel, ssel;
    logic [CW-1:0] fill [2];
    row_t mem [2][DEPTH];
    assign wfill = fill[wsel];
    assign bus.wr_ready = wfill < CW'(DEPTH);
    assign rd_row = mem[ssel][rd_ptr[PW-1:0]];
    assign head = mem[wsel][0];
    always_ff @(posedge clk) if (beat) mem[wsel][wfill[PW-1:0]] <= bus.wr_data;
`else
    logic [CW-1:0] fill;
    row_t mem [DEPTH];
    assign wfill = fill;
    assign bus.wr_ready = state == IDLE && fill < CW'(DEPTH);
    assign rd_row = mem[rd_ptr[PW-1:0]];
    assign head = mem[0];
    always_ff @(posedge clk) if (beat) mem[wfill[PW-1:0]] <= bus.wr_data;
`endif
    assign beat = bus.wr_valid && bus.wr_ready;
    assign go = bus.start && state == IDLE && (beat || wfill != '0);
    // with a single lane nothing needs draining, so the last row completes the tile directly
    assign fin = state == FLUSH ? fcnt == FLAST : state == STREAM && rd_ptr == len && PORTS == 1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            len <= '0;
            rd_ptr <= '0;
            fcnt <= '0;
            bus.out <= '0;
            bus.out_valid <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
            fill <= '{default: '0};
            wsel <= 1'b0;
            ssel <= 1'b0;
`else
            fill <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
            if (beat) fill[wsel] <= wfill + CW'(1);
`else
            fill <= fill + CW'(beat);
`endif
            case (state)
                IDLE: if (go) begin
                    state <= STREAM;
                    len <= wfill + CW'(beat);
                    rd_ptr <= CW'(1);
                    // an empty bank means row 0 is the one arriving this very cycle
                    bus.out <= wfill == '0 ? bus.wr_data : head;
                    bus.out_valid <= 1'b1;
                    bus.busy <= 1'b1;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
                    ssel <= wsel;
                    wsel <= ~wsel;
`endif
                end
                STREAM: begin
                    state <= rd_ptr == len ? FLUSH : STREAM;
                    bus.out <= rd_ptr == len ? '0 : rd_row;
                    bus.out_valid <= rd_ptr != len;
                    rd_ptr <= rd_ptr + CW'(1);
                    fcnt <= '0;
                end
                FLUSH: fcnt <= fcnt + FW'(1);
                default: state <= IDLE;
            endcase
            if (fin) begin
                state <= IDLE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
                fill[ssel] <= '0;
`else
                fill <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed and random stimulus against a queue-level model of tile streaming.
module tb_systolic_feeder;
    localparam int DW = 8, P = 4, D = 4;
    typedef logic [P-1:0][DW-1:0] row_t;
    typedef struct packed {row_t row; logic valid; logic busy; logic done;} exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    int checks = 0, errors = 0;
    row_t stored[$];
    exp_t exp_q[$];
    exp_t cur = '0;
    systolic_feeder_if #(.DATA_WIDTH(DW), .PORTS(P)) bus ();
    systolic_feeder #(.DATA_WIDTH(DW), .PORTS(P), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic check_outs(input string tag);
        chk({tag, ".out"}, bus.out, cur.row);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(cur.valid));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(cur.busy));
        chk({tag, ".done"}, 32'(bus.done), 32'(cur.done));
    endtask
    // one clock: apply inputs, predict acceptance, then check the registered outputs after the edge
    task automatic cycle(input logic wv, input row_t wd, input logic st);
        logic ready;
        bus.wr_valid = wv;
        bus.wr_data = wd;
        bus.start = st;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
        ready = stored.size() < D;
`else
        ready = !cur.busy && stored.size() < D;
`endif
        #1;
        chk("wr_ready", 32'(bus.wr_ready), 32'(ready));
        if (wv && ready) stored.push_back(wd);
        if (st && !cur.busy && stored.size() > 0) begin
            foreach (stored[i]) exp_q.push_back('{stored[i], 1'b1, 1'b1, 1'b0});
            repeat (P - 1) exp_q.push_back('{'0, 1'b0, 1'b1, 1'b0});
            exp_q.push_back('{'0, 1'b0, 1'b0, 1'b1});
            stored.delete();
        end
        @(posedge clk);
        #1;
        cur = exp_q.size() != 0 ? exp_q.pop_front() : '0;
        check_outs("cyc");
    endtask
    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0, 1'b0);
    endtask
    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data = '0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_outs("reset");
        chk("reset.wr_ready", 32'(bus.wr_ready), 32'd1);
        rst_n = 1'b1;
        // three rows, seven-cycle tile
        cycle(1'b1, row_t'(32'h01010101), 1'b0);
        cycle(1'b1, row_t'(32'h02020202), 1'b0);
        cycle(1'b1, row_t'(32'h03030303), 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("t1.first_row", bus.out, 32'h01010101);
        idle(8);
        // overfill: fifth row is dropped
        for (int i = 0; i < 5; i++) cycle(1'b1, row_t'($urandom), 1'b0);
        cycle(1'b0, '0, 1'b1);
        idle(9);
        // start with nothing stored, then start while busy
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, row_t'($urandom), 1'b0);
        cycle(1'b1, row_t'($urandom), 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        idle(6);
        // write in the start cycle joins the tile
        cycle(1'b1, row_t'(32'h5a5a5a5a), 1'b0);
        cycle(1'b1, row_t'(32'haaaaaaaa), 1'b1);
        idle(8);
        // asynchronous reset mid-stream
        cycle(1'b1, row_t'(32'h01010101), 1'b0);
        cycle(1'b1, row_t'(32'h02020202), 1'b0);
        cycle(1'b1, row_t'(32'h03030303), 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        stored.delete();
        exp_q.delete();
        cur = '0;
        check_outs("async_rst");
        @(posedge clk);
        #1;
        check_outs("in_rst");
        rst_n = 1'b1;
        idle(3);
        cycle(1'b1, row_t'($urandom), 1'b1);
        idle(6);
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
        // load the other bank during streaming and restart in the done cycle
        for (int i = 0; i < 4; i++) cycle(1'b1, row_t'($urandom), 1'b0);
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, row_t'($urandom), 1'b0);
        idle(3);
        chk("db.done", 32'(bus.done), 32'd1);
        cycle(1'b0, '0, 1'b1);
        chk("db.no_gap", 32'(bus.out_valid), 32'd1);
        idle(9);
`endif
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), row_t'($urandom), $urandom_range(0, 7) == 0);
        idle(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
